// File: rtl/red_pkg.sv
// rtl/red_pkg.sv - shared state encoding, latency constant and byte extension helper
package red_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] S_A  = 2'd1;
  localparam logic [1:0] S_B  = 2'd2;
  localparam logic [1:0] S_F  = 2'd3;

  localparam int RED_LAT = 4;

  function automatic logic [8:0] sext9(input logic [7:0] i_byte);
    return {i_byte[7], i_byte};
  endfunction

endpackage

// File: rtl/red_add9.sv
// rtl/red_add9.sv - 9-bit signed adder with 10-bit result, three chained CLA cells
module red_add9 (
  input  logic signed [8:0] i_a,
  input  logic signed [8:0] i_b,
  input  logic              i_cin,
  output logic signed [9:0] o_sum
);

  // Operands widened to 12 bits so the three cells cover the signed 10-bit result.
  logic [11:0] w_a;
  logic [11:0] w_b;
  logic [11:0] w_s;
  logic [2:0]  w_cy;
  logic        w_unused;

  assign w_a = {{3{i_a[8]}}, i_a};
  assign w_b = {{3{i_b[8]}}, i_b};

  red_cla4 u_cla0 (.i_a(w_a[3:0]),  .i_b(w_b[3:0]),  .i_cin(i_cin),
                   .o_sum(w_s[3:0]),  .o_cout(w_cy[0]));
  red_cla4 u_cla1 (.i_a(w_a[7:4]),  .i_b(w_b[7:4]),  .i_cin(w_cy[0]),
                   .o_sum(w_s[7:4]),  .o_cout(w_cy[1]));
  red_cla4 u_cla2 (.i_a(w_a[11:8]), .i_b(w_b[11:8]), .i_cin(w_cy[1]),
                   .o_sum(w_s[11:8]), .o_cout(w_cy[2]));

  assign o_sum    = w_s[9:0];
  assign w_unused = &{1'b0, w_s[11:10], w_cy[2]};

endmodule

// File: rtl/red_cla4.sv
// rtl/red_cla4.sv - 4-bit carry-lookahead adder cell
module red_cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];

endmodule

// File: rtl/red_ctrl.sv
// rtl/red_ctrl.sv - four-byte signed reduction over one time-multiplexed 9-bit adder
module red_ctrl
  import red_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Sum
);

  logic [1:0]  r_state;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [8:0]  r_pab;
  logic [8:0]  r_pcd;
  logic [15:0] r_sum;
  logic        r_done;

  logic [8:0]  w_op_a;
  logic [8:0]  w_op_b;
  logic [9:0]  w_sum;

  always_comb begin
    w_op_a = r_pab;
    w_op_b = r_pcd;
    case (r_state)
      S_A: begin
        w_op_a = sext9(r_a[7:0]);
        w_op_b = sext9(r_a[15:8]);
      end
      S_B: begin
        w_op_a = sext9(r_b[7:0]);
        w_op_b = sext9(r_b[15:8]);
      end
      default: ;
    endcase
  end

  red_add9 u_add (.i_a(w_op_a), .i_b(w_op_b), .i_cin(1'b0), .o_sum(w_sum));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_pab   <= 9'h000;
      r_pcd   <= 9'h000;
      r_sum   <= 16'h0000;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_state <= S_A;
          end
        end
        S_A: begin
          r_pab   <= w_sum[8:0];
          r_state <= S_B;
        end
        S_B: begin
          r_pcd   <= w_sum[8:0];
          r_state <= S_F;
        end
        default: begin
          r_sum   <= {{6{w_sum[9]}}, w_sum};
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign Sum  = r_sum;

endmodule

// File: tb/tb_red_ctrl.sv
// tb/tb_red_ctrl.sv - self-checking bench for red_ctrl against a byte-sum reference
module tb_red_ctrl;
  import red_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] Sum;

  int n_checks = 0;
  int n_fail   = 0;

  red_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Sum(Sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
    byte a0, a1, b0, b1;
    int  s;
    a0 = a[7:0];
    a1 = a[15:8];
    b0 = b[7:0];
    b1 = b[15:8];
    s  = int'(a0) + int'(a1) + int'(b0) + int'(b1);
    return s[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: quiet inputs, 1: random start/operand noise while busy, 2: operands forced to 7F7F
  task automatic run_req(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp, input int mode);
    A = a;
    B = b;
    start = 1'b1;
    tick();
    for (int c = 1; c < RED_LAT; c++) begin
      check("busy_in_flight", {15'b0, busy}, 16'd1);
      check("done_in_flight", {15'b0, done}, 16'd0);
      start = 1'b0;
      if (mode == 1) begin
        start = 1'($urandom_range(0, 1));
        A = 16'($urandom);
        B = 16'($urandom);
      end else if (mode == 2) begin
        A = 16'h7F7F;
        B = 16'h7F7F;
      end
      tick();
    end
    check("busy_at_done", {15'b0, busy}, 16'd0);
    check("done_pulse", {15'b0, done}, 16'd1);
    check("sum", Sum, exp);
    start = 1'b0;
    tick();
    check("done_single", {15'b0, done}, 16'd0);
    check("sum_hold", Sum, exp);
  endtask

  logic [15:0] sa [12];
  logic [15:0] sb [12];
  int          n_done;
  logic        exp_done;
  logic        exp_busy;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = 16'h0000;
    B     = 16'h0000;
    tick();
    start = 1'b1;
    A     = 16'h1234;
    tick();
    check("rst_busy", {15'b0, busy}, 16'd0);
    check("rst_done", {15'b0, done}, 16'd0);
    check("rst_sum", Sum, 16'h0000);
    start = 1'b0;
    rst   = 1'b0;

    run_req(16'h0102, 16'h0304, 16'h000A, 0);
    run_req(16'h8080, 16'h8080, 16'hFE00, 0);
    run_req(16'h7F7F, 16'h7F7F, 16'h01FC, 0);
    run_req(16'hFF01, 16'h807F, 16'hFFFF, 2);

    // Start held high: acceptances only at cycles 0, 4 and 8.
    n_done = 0;
    for (int k = 0; k < 14; k++) begin
      if (k < 12) begin
        sa[k] = 16'($urandom);
        sb[k] = 16'($urandom);
        A     = sa[k];
        B     = sb[k];
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      exp_done = ((k + 1) % 4 == 0) && (k + 1 <= 12);
      exp_busy = ((k + 1) % 4 != 0) && (k + 1 <= 11);
      check("b2b_done", {15'b0, done}, {15'b0, exp_done});
      check("b2b_busy", {15'b0, busy}, {15'b0, exp_busy});
      if (done) n_done++;
      if (exp_done) check("b2b_sum", Sum, ref_sum(sa[k - 3], sb[k - 3]));
    end
    check("b2b_count", 16'(n_done), 16'd3);

    // Reset while in S_B aborts the request.
    A     = 16'h7F7F;
    B     = 16'h7F7F;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("abort_busy", {15'b0, busy}, 16'd0);
    check("abort_done", {15'b0, done}, 16'd0);
    check("abort_sum", Sum, 16'h0000);
    rst = 1'b0;
    run_req(16'h0102, 16'hFDFE, ref_sum(16'h0102, 16'hFDFE), 0);

    for (int i = 0; i < 10000; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_req(ra, rb, ref_sum(ra, rb), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
